// File: rtl/multichannel_dac_sequencer.sv
// Streams one waveform table per DAC channel in lockstep onto a wide AXI-Stream bus, continuous or N-pass burst.
// Latency: trigger edge in cycle n -> PLAYING at n+1 -> word 0 valid on TDATA at n+2; table read latency 1 clock.
// Backpressure: TREADY=0 freezes TDATA/TVALID and the word pointer; TDATA is forced to zero outside PLAYING.
module multichannel_dac_sequencer #(
  parameter int NCHAN             = 2,
  parameter int AXIS_DATA_WIDTH   = 256,
  parameter int DAC_DATA_WIDTH    = 16,
  parameter int DAC_ADDRESS_WIDTH = 14,
  parameter int REPEAT_WIDTH      = 16,
  parameter int ERRCNT_WIDTH      = 8,
  localparam int SPC  = AXIS_DATA_WIDTH / DAC_DATA_WIDTH,
  localparam int LSPC = $clog2(SPC),
  localparam int RAW  = DAC_ADDRESS_WIDTH - LSPC,
  localparam int CHW  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                             axis_CLK,
  input  logic                             axis_RESET,
  input  logic                             cfgRun,
  input  logic                             cfgMode,
  input  logic [RAW-1:0]                   cfgLastIdx,
  input  logic [REPEAT_WIDTH-1:0]          cfgRepeats,
  input  logic                             wrStrobe,
  input  logic [CHW-1:0]                   wrChannel,
  input  logic [DAC_ADDRESS_WIDTH-1:0]     wrAddress,
  input  logic [DAC_DATA_WIDTH-1:0]        wrData,
  input  logic                             trigger,
  output logic [NCHAN*AXIS_DATA_WIDTH-1:0] axis_TDATA,
  output logic                             axis_TVALID,
  input  logic                             axis_TREADY,
  output logic [1:0]                       stState,
  output logic                             stSynced,
  output logic [ERRCNT_WIDTH-1:0]          stSyncErrors,
  output logic                             stDone
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PLAYING = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CHW:0] NCHAN_W = (CHW + 1)'(NCHAN);

  state_t                     state;
  logic [AXIS_DATA_WIDTH-1:0] mem [NCHAN][2**RAW];
  logic [RAW-1:0]             idx;       // next word to fetch
  logic [RAW-1:0]             held;      // word currently on TDATA
  logic [RAW-1:0]             last_q;
  logic                       mode_q;
  logic [REPEAT_WIDTH-1:0]    reps_q;
  logic [REPEAT_WIDTH-1:0]    pass;
  logic [REPEAT_WIDTH-1:0]    pass_max;
  logic                       trigger_d1;
  logic                       trg_edge;
  logic                       in_play;
  logic                       accept;
  logic                       issue;
  logic                       cont_trg;
  logic                       burst_end;
  logic                       stay_play;
  logic [RAW-1:0]             rd_addr;

  assign stState   = state;
  assign trg_edge  = trigger & ~trigger_d1;
  assign in_play   = (state == PLAYING);
  assign accept    = axis_TVALID & axis_TREADY;
  // A new word may be fetched whenever the output slot is empty or being consumed.
  assign issue     = ~axis_TVALID | axis_TREADY;
  // A continuous-mode retrigger restarts the table: word 0 is fetched in the trigger cycle.
  assign cont_trg  = in_play & ~mode_q & trg_edge;
  assign rd_addr   = cont_trg ? '0 : idx;
  // A repeat count of zero behaves as a single pass.
  assign pass_max  = (reps_q == '0) ? '0 : reps_q - REPEAT_WIDTH'(1);
  assign burst_end = in_play & mode_q & accept & (held == last_q) & (pass == pass_max);
  assign stay_play = cfgRun & in_play & ~burst_end;

  // Table write port: one sample lane of one word; out-of-range channels are dropped.
  always_ff @(posedge axis_CLK) begin
    if (wrStrobe && ({1'b0, wrChannel} < NCHAN_W)) begin
      mem[wrChannel][wrAddress[DAC_ADDRESS_WIDTH-1:LSPC]][wrAddress[LSPC-1:0]*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] <= wrData;
    end
  end

  // Output data register: fetches all channels when the slot frees, zero whenever not playing.
  always_ff @(posedge axis_CLK or posedge axis_RESET) begin
    if (axis_RESET) begin
      axis_TDATA <= '0;
    end else if (!stay_play) begin
      axis_TDATA <= '0;
    end else if (issue) begin
      for (int c = 0; c < NCHAN; c++) begin
        axis_TDATA[c*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] <= mem[c][rd_addr];
      end
    end
  end

  // Sequencer FSM with word pointer, pass counter, trigger phase check and status outputs.
  always_ff @(posedge axis_CLK or posedge axis_RESET) begin
    if (axis_RESET) begin
      state        <= IDLE;
      idx          <= '0;
      held         <= '0;
      last_q       <= '0;
      mode_q       <= 1'b0;
      reps_q       <= '0;
      pass         <= '0;
      trigger_d1   <= 1'b0;
      axis_TVALID  <= 1'b0;
      stSynced     <= 1'b0;
      stSyncErrors <= '0;
      stDone       <= 1'b0;
    end else begin
      trigger_d1 <= trigger;
      stDone     <= 1'b0;
      if (!cfgRun) begin
        // Dropping run aborts from any state; the error count survives.
        state       <= IDLE;
        idx         <= '0;
        pass        <= '0;
        axis_TVALID <= 1'b0;
        stSynced    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            last_q <= cfgLastIdx;
            mode_q <= cfgMode;
            reps_q <= cfgRepeats;
            idx    <= '0;
            state  <= ARMED;
          end
          ARMED: begin
            if (trg_edge) begin
              idx   <= '0;
              pass  <= '0;
              state <= PLAYING;
            end
          end
          PLAYING: begin
            if (burst_end) begin
              axis_TVALID <= 1'b0;
              stDone      <= 1'b1;
              state       <= DONE;
            end else begin
              if (accept && (held == last_q)) begin
                pass <= pass + REPEAT_WIDTH'(1);
              end
              if (issue) begin
                held        <= rd_addr;
                idx         <= (rd_addr == last_q) ? '0 : rd_addr + RAW'(1);
                axis_TVALID <= 1'b1;
              end else if (cont_trg) begin
                idx <= '0;
              end
              if (cont_trg) begin
                if (idx == '0) begin
                  stSynced <= 1'b1;
                end else begin
                  stSynced <= 1'b0;
                  if (stSyncErrors != '1) begin
                    stSyncErrors <= stSyncErrors + ERRCNT_WIDTH'(1);
                  end
                end
              end
            end
          end
          DONE: begin
            axis_TVALID <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multichannel_dac_sequencer.sv
// Bench for multichannel_dac_sequencer: table vectors, randomized bursts/streams and hand-written corner sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// A flat sample-array model predicts every accepted word, burst length and trigger-phase result.
module tb_multichannel_dac_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_run = 1'b0;
  logic         cfg_mode = 1'b0;
  logic [9:0]   cfg_last = '0;
  logic [15:0]  cfg_reps = '0;
  logic         wr_strobe = 1'b0;
  logic [0:0]   wr_ch = '0;
  logic [13:0]  wr_addr = '0;
  logic [15:0]  wr_data = '0;
  logic         trigger = 1'b0;
  logic [511:0] axis_tdata;
  logic         axis_tvalid;
  logic         axis_tready = 1'b1;
  logic [1:0]   st_state;
  logic         st_synced;
  logic [7:0]   st_errs;
  logic         st_done;

  // Small three-channel instance, used for the out-of-range channel write check.
  logic         w3_strobe = 1'b0;
  logic [1:0]   w3_ch = '0;
  logic [5:0]   w3_addr = '0;
  logic [15:0]  w3_data = '0;
  logic [191:0] tdata3;
  logic         tvalid3;
  logic [1:0]   state3;
  logic         synced3;
  logic [7:0]   errs3;
  logic         done3;

  int total = 0;
  int bad = 0;
  int exp_errs = 0;
  bit exp_synced = 1'b0;
  logic [15:0] tab [2][16384];

  typedef struct { int last; int reps; int beats; } bvec_t;
  bvec_t vec [5];

  always #5 clk = ~clk;

  multichannel_dac_sequencer dut (
    .axis_CLK(clk), .axis_RESET(rst), .cfgRun(cfg_run), .cfgMode(cfg_mode),
    .cfgLastIdx(cfg_last), .cfgRepeats(cfg_reps), .wrStrobe(wr_strobe), .wrChannel(wr_ch),
    .wrAddress(wr_addr), .wrData(wr_data), .trigger(trigger), .axis_TDATA(axis_tdata),
    .axis_TVALID(axis_tvalid), .axis_TREADY(axis_tready), .stState(st_state),
    .stSynced(st_synced), .stSyncErrors(st_errs), .stDone(st_done)
  );

  multichannel_dac_sequencer #(.NCHAN(3), .AXIS_DATA_WIDTH(64), .DAC_ADDRESS_WIDTH(6)) dut3 (
    .axis_CLK(clk), .axis_RESET(rst), .cfgRun(cfg_run), .cfgMode(cfg_mode),
    .cfgLastIdx(cfg_last[3:0]), .cfgRepeats(cfg_reps), .wrStrobe(w3_strobe), .wrChannel(w3_ch),
    .wrAddress(w3_addr), .wrData(w3_data), .trigger(trigger), .axis_TDATA(tdata3),
    .axis_TVALID(tvalid3), .axis_TREADY(axis_tready), .stState(state3),
    .stSynced(synced3), .stSyncErrors(errs3), .stDone(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected bus word: SPC samples of each channel's table, sample 0 in the LSBs.
  function automatic logic [511:0] word(input int w);
    logic [511:0] r;
    r = '0;
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 16; s++)
        r[c*256 + s*16 +: 16] = tab[c][w*16 + s];
    return r;
  endfunction

  task automatic wr(input int ch, input int a, input logic [15:0] d);
    wr_strobe = 1'b1; wr_ch = ch[0]; wr_addr = a[13:0]; wr_data = d;
    tick();
    wr_strobe = 1'b0;
    tab[ch][a] = d;
  endtask

  task automatic w3(input int ch, input int a, input logic [15:0] d);
    w3_strobe = 1'b1; w3_ch = ch[1:0]; w3_addr = a[5:0]; w3_data = d;
    tick();
    w3_strobe = 1'b0;
  endtask

  // Return to IDLE, load config, fire a start trigger; ends in the cycle word 0 must be valid.
  task automatic start_play(input bit mode, input int last, input int reps);
    trigger = 1'b0; axis_tready = 1'b1; cfg_run = 1'b0;
    tick();
    exp_synced = 1'b0;
    chk("idle_state", st_state, 0);
    chk("idle_synced", st_synced, 0);
    chk("errs_hold", st_errs, exp_errs);
    cfg_mode = mode; cfg_last = 10'(last); cfg_reps = 16'(reps); cfg_run = 1'b1;
    tick();
    chk("armed_state", st_state, 1);
    chk("armed_tdata", axis_tdata, 0);
    chk("armed_valid", axis_tvalid, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("play_entry", st_state, 2);
    chk("valid_n1", axis_tvalid, 0);
    tick();
    chk("valid_n2", axis_tvalid, 1);
  endtask

  // Stream checker: each accepted beat must carry the next table word; stalls must hold the bus.
  task automatic play(input bit mode, input int last, input int reps, input int gap, input int ntrig,
                      input bit rr, input int ncyc, output int beats, output int dones);
    int ptr, since, left;
    logic [511:0] held;
    bit stalled, trig_now, sync_chk;
    start_play(mode, last, reps);
    ptr = 0; beats = 0; dones = 0; since = 0; left = ntrig; stalled = 1'b0; held = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (stalled) begin
        chk("stall_hold", axis_tdata, held);
        chk("stall_valid", axis_tvalid, 1);
      end
      if (st_done) dones++;
      if (st_state == 2'd3) break;
      since++;
      trig_now = (left > 0) && (since >= gap);
      axis_tready = (trig_now || !rr) ? 1'b1 : ($urandom_range(0, 3) != 0);
      stalled = axis_tvalid && !axis_tready;
      held = axis_tdata;
      if (axis_tvalid && axis_tready) begin
        chk("beat_data", axis_tdata, word(ptr));
        beats++;
        ptr = (ptr == last) ? 0 : ptr + 1;
      end
      sync_chk = 1'b0;
      if (trig_now) begin
        trigger = 1'b1; left--; since = 0;
        if (!mode) begin
          exp_synced = (ptr == 0);
          if (!exp_synced && exp_errs < 255) exp_errs++;
          ptr = 0;
          sync_chk = 1'b1;
        end
      end else begin
        trigger = 1'b0;
      end
      tick();
      if (sync_chk) begin
        chk("synced", st_synced, exp_synced);
        chk("sync_errs", st_errs, exp_errs);
      end
    end
    trigger = 1'b0; axis_tready = 1'b1;
  endtask

  task automatic burst_check(input int last, input int reps, input int exp_beats, input bit rr);
    int beats, dones;
    play(1'b1, last, reps, $urandom_range(2, 6), 1, rr, 400, beats, dones);
    chk("burst_beats", beats, exp_beats);
    chk("burst_dones", dones, 1);
    chk("burst_state", st_state, 3);
    chk("burst_tdata0", axis_tdata, 0);
    chk("burst_valid0", axis_tvalid, 0);
    tick();
    chk("done_1cyc", st_done, 0);
    trigger = 1'b1; tick(); trigger = 1'b0; tick(); tick();
    chk("done_retrig", st_state, 3);
    chk("done_retrig_v", axis_tvalid, 0);
  endtask

  initial begin
    int beats, dones, last, reps, nd;
    logic [191:0] e3;
    vec[0] = '{1, 3, 6};
    vec[1] = '{0, 0, 1};
    vec[2] = '{3, 1, 4};
    vec[3] = '{2, 2, 6};
    vec[4] = '{0, 4, 4};

    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_state", st_state, 0);
    chk("rst_valid", axis_tvalid, 0);
    chk("rst_tdata", axis_tdata, 0);
    chk("rst_synced", st_synced, 0);
    chk("rst_errs", st_errs, 0);
    chk("rst_done", st_done, 0);

    // Ramp on channel 0, negated ramp on channel 1, words 0..7.
    for (int a = 0; a < 128; a++) begin
      wr(0, a, 16'(a));
      wr(1, a, 16'(0 - a));
    end

    // Continuous streaming, lastIdx=3, always ready.
    play(1'b0, 3, 0, 0, 0, 1'b0, 12, beats, dones);
    chk("cont_beats", beats, 12);

    // Stall sequence TREADY 1,0,0,1.
    start_play(1'b0, 3, 0);
    chk("stall_w0", axis_tdata, word(0));
    axis_tready = 1'b1; tick();
    chk("stall_w1a", axis_tdata, word(1));
    axis_tready = 1'b0; tick();
    chk("stall_w1b", axis_tdata, word(1));
    axis_tready = 1'b0; tick();
    chk("stall_w1c", axis_tdata, word(1));
    axis_tready = 1'b1; tick();
    chk("stall_w2", axis_tdata, word(2));

    // Trigger phase: aligned every 8 beats, then misaligned every 7 until saturation.
    play(1'b0, 3, 0, 8, 4, 1'b0, 45, beats, dones);
    chk("sync8_flag", st_synced, 1);
    chk("sync8_errs", st_errs, 0);
    play(1'b0, 3, 0, 7, 260, 1'b0, 260*7 + 10, beats, dones);
    chk("sat_errs", st_errs, 255);
    chk("sat_flag", st_synced, 0);
    play(1'b0, 3, 0, 8, 1, 1'b0, 12, beats, dones);
    chk("resync_flag", st_synced, 1);
    chk("resync_errs", st_errs, 255);

    // Burst vectors.
    for (int i = 0; i < 5; i++) burst_check(vec[i].last, vec[i].reps, vec[i].beats, 1'b0);

    // Randomized bursts and a randomized continuous stream with retriggers.
    for (int i = 0; i < 6; i++) begin
      last = $urandom_range(0, 7);
      reps = $urandom_range(0, 3);
      burst_check(last, reps, (last + 1) * ((reps == 0) ? 1 : reps), 1'b1);
    end
    play(1'b0, $urandom_range(0, 7), 0, $urandom_range(3, 12), 6, 1'b1, 100, beats, dones);
    chk("rand_cont_live", beats > 0, 1);

    // Asynchronous reset mid-play, then tables must be intact.
    play(1'b0, 3, 0, 0, 0, 1'b1, 6, beats, dones);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", axis_tvalid, 0);
    chk("arst_tdata", axis_tdata, 0);
    chk("arst_state", st_state, 0);
    tick(); tick();
    rst = 1'b0;
    exp_errs = 0;
    exp_synced = 1'b0;
    tick();
    chk("arst_errs", st_errs, 0);
    play(1'b0, 7, 0, 0, 0, 1'b1, 40, beats, dones);

    // Run dropped mid-burst: IDLE next clock, no completion pulse.
    start_play(1'b1, 3, 3);
    repeat (4) tick();
    cfg_run = 1'b0;
    tick();
    chk("drop_state", st_state, 0);
    chk("drop_valid", axis_tvalid, 0);
    chk("drop_tdata", axis_tdata, 0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      if (st_done) nd++;
      tick();
    end
    chk("drop_nodone", nd, 0);

    // Out-of-range channel write on the three-channel instance.
    e3 = '0;
    for (int c = 0; c < 3; c++)
      for (int s = 0; s < 4; s++) begin
        w3(c, s, 16'(16'h1000 + c*16 + s));
        e3[c*64 + s*16 +: 16] = 16'(16'h1000 + c*16 + s);
      end
    for (int s = 0; s < 4; s++) w3(3, s, 16'hdead);
    start_play(1'b0, 0, 0);
    chk("ch_guard_v", tvalid3, 1);
    chk("ch_guard_d", tdata3, e3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
